// File: rtl/burst_master.sv
// Single-outstanding burst master: sequences AR/R or AW/W/B handshakes toward the memory
// slave, streams read beats back and reports one completion (with timeout abort) per command.
module burst_master #(
  parameter int unsigned TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [7:0]  cmd_addr,
  input  logic [3:0]  cmd_len,
  input  logic [3:0]  cmd_id,
  input  logic [7:0]  wd_data,
  input  logic        wd_valid,
  output logic        wd_ready,
  output logic [7:0]  rd_data,
  output logic        rd_err,
  output logic        rd_valid,
  output logic        rd_last,
  output logic        done,
  output logic [4:0]  done_resp,
  output logic        done_tmo,
  output logic        ARVALID,
  input  logic        ARREADY,
  output logic [15:0] IN,
  output logic        RREADY,
  input  logic        RVALID,
  input  logic        RLAST,
  input  logic [8:0]  OUT,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [11:0] AWIN,
  output logic        WVALID,
  output logic        WLAST,
  output logic [7:0]  WDATA,
  input  logic        WREADY,
  input  logic        BVALID,
  output logic        BREADY,
  input  logic [4:0]  BRESP,
  input  logic        RIDLE,
  input  logic        WIDLE
);

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned RESP_W = 5;
  localparam int unsigned BEAT_W = 5;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAITIDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE
  } state_e;

  state_e state, state_next;

  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [ID_W-1:0]   id_q;
  logic              write_q;
  logic              any_err_q;
  logic [BEAT_W-1:0] beat_cnt;
  logic [TMO_W-1:0]  tmo_cnt;

  logic accept, busy, xfer, last_beat, tmo_abort;

  logic              cmd_ready_d, arvalid_d, rready_d, awvalid_d, bready_d;
  logic              rd_valid_d, rd_err_d, rd_last_d, done_d, done_tmo_d;
  logic [DATA_W-1:0] rd_data_d;
  logic [RESP_W-1:0] done_resp_d;

  assign accept    = (state == S_IDLE) && cmd_valid;
  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign last_beat = (beat_cnt == BEAT_W'(len_q)) || RLAST;

  // Write channel is a direct pass-through of the user write stream while in W.
  assign WVALID   = (state == S_W) && wd_valid;
  assign WDATA    = wd_data;
  assign WLAST    = (state == S_W) && (beat_cnt == BEAT_W'(len_q));
  assign wd_ready = (state == S_W) && WREADY;

  assign IN   = {addr_q, len_q, id_q};
  assign AWIN = {addr_q, id_q};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; a stalled handshake overrides everything once the timeout is reached.
  always_comb begin
    state_next = state;
    xfer       = 1'b0;
    tmo_abort  = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_write) state_next = WIDLE ? S_AW : S_WAITIDLE;
          else           state_next = RIDLE ? S_AR : S_WAITIDLE;
        end
      end
      S_WAITIDLE: begin
        if (write_q && WIDLE)        state_next = S_AW;
        else if (!write_q && RIDLE)  state_next = S_AR;
      end
      S_AR: if (ARREADY) state_next = S_R;
      S_R: begin
        if (RVALID) begin
          xfer = 1'b1;
          if (last_beat) state_next = S_DONE;
        end
      end
      S_AW: if (AWREADY) state_next = S_W;
      S_W: begin
        if (WVALID && WREADY) begin
          xfer = 1'b1;
          if (WLAST) state_next = S_B;
        end
      end
      S_B:    if (BVALID) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (busy && !xfer && (state_next == state) && (tmo_cnt == TMO_W'(TIMEOUT - 1))) begin
      tmo_abort  = 1'b1;
      state_next = S_DONE;
    end
  end

  // Output logic: next values of the registered outputs, decoded from the upcoming state.
  always_comb begin
    cmd_ready_d = (state_next == S_IDLE);
    arvalid_d   = (state_next == S_AR);
    rready_d    = (state_next == S_R);
    awvalid_d   = (state_next == S_AW);
    bready_d    = (state_next == S_B);
    rd_valid_d  = (state == S_R) && xfer;
    rd_data_d   = rd_valid_d ? OUT[8:1] : '0;
    rd_err_d    = rd_valid_d && OUT[0];
    rd_last_d   = rd_valid_d && last_beat;
    done_d      = (state_next == S_DONE);
    done_tmo_d  = tmo_abort;
    done_resp_d = '0;
    if ((state_next == S_DONE) && !tmo_abort) begin
      if (write_q) done_resp_d = BRESP;
      else         done_resp_d = {any_err_q | rd_err_d, id_q};
    end
  end

  // Registered outputs, latched command, beat and timeout counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ready <= 1'b1;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
      AWVALID   <= 1'b0;
      BREADY    <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_err    <= 1'b0;
      rd_last   <= 1'b0;
      done      <= 1'b0;
      done_resp <= '0;
      done_tmo  <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      id_q      <= '0;
      write_q   <= 1'b0;
      any_err_q <= 1'b0;
      beat_cnt  <= '0;
      tmo_cnt   <= '0;
    end else begin
      cmd_ready <= cmd_ready_d;
      ARVALID   <= arvalid_d;
      RREADY    <= rready_d;
      AWVALID   <= awvalid_d;
      BREADY    <= bready_d;
      rd_valid  <= rd_valid_d;
      rd_data   <= rd_data_d;
      rd_err    <= rd_err_d;
      rd_last   <= rd_last_d;
      done      <= done_d;
      done_resp <= done_resp_d;
      done_tmo  <= done_tmo_d;
      if (accept) begin
        addr_q    <= cmd_addr;
        len_q     <= cmd_len;
        id_q      <= cmd_id;
        write_q   <= cmd_write;
        any_err_q <= 1'b0;
        beat_cnt  <= '0;
      end else begin
        if (xfer)     beat_cnt  <= beat_cnt + BEAT_W'(1);
        if (rd_err_d) any_err_q <= 1'b1;
      end
      if (!busy || (state_next != state) || xfer) tmo_cnt <= '0;
      else                                        tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

endmodule

// File: tb/tb_burst_master.sv
// Bench for burst_master: behavioural memory slave plus scoreboard queues for read beats
// and completions, driven by one task per scenario.
module tb_burst_master;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [3:0]  cmd_len, cmd_id;
  logic [7:0]  wd_data;
  logic        wd_valid, wd_ready;
  logic [7:0]  rd_data;
  logic        rd_err, rd_valid, rd_last, done, done_tmo;
  logic [4:0]  done_resp;
  logic        ARVALID, ARREADY, RREADY, RVALID, RLAST;
  logic [15:0] IN;
  logic [8:0]  OUT;
  logic        AWVALID, AWREADY, WVALID, WLAST, WREADY, BVALID, BREADY;
  logic [11:0] AWIN;
  logic [7:0]  WDATA;
  logic [4:0]  BRESP;
  logic        RIDLE, WIDLE;

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0;
  int aw_viol = 0;

  logic [9:0] exp_rd[$];
  logic [5:0] exp_done[$];
  logic [7:0] wbytes [16];

  burst_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
    .wd_data(wd_data), .wd_valid(wd_valid), .wd_ready(wd_ready),
    .rd_data(rd_data), .rd_err(rd_err), .rd_valid(rd_valid), .rd_last(rd_last),
    .done(done), .done_resp(done_resp), .done_tmo(done_tmo),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .IN(IN), .RREADY(RREADY),
    .RVALID(RVALID), .RLAST(RLAST), .OUT(OUT),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWIN(AWIN),
    .WVALID(WVALID), .WLAST(WLAST), .WDATA(WDATA), .WREADY(WREADY),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .RIDLE(RIDLE), .WIDLE(WIDLE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int a);
    return 8'(a) ^ 8'h5A;
  endfunction

  // Memory slave model: out-of-range read addresses (>= 0x100) return an error beat.
  logic        ar_en, aw_en;
  int unsigned w_delay;
  logic [7:0]  mem [256];
  logic        rbusy, wbusy;
  logic [8:0]  rptr;
  logic [3:0]  rleft, wid;
  logic [7:0]  wptr;
  int unsigned wdly;

  assign RIDLE   = !rbusy && !RVALID;
  assign ARREADY = ar_en && RIDLE;
  assign WIDLE   = !wbusy && (wdly == 0);
  assign AWREADY = aw_en && WIDLE;
  assign WREADY  = wbusy && !BVALID;
  assign BRESP   = {1'b0, wid};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rbusy <= 1'b0; rptr <= '0; rleft <= '0; RVALID <= 1'b0; RLAST <= 1'b0; OUT <= '0;
      wbusy <= 1'b0; wptr <= '0; wid <= '0; wdly <= 0; BVALID <= 1'b0;
      for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
    end else begin
      if (ARVALID && ARREADY) begin
        rbusy <= 1'b1; rptr <= {1'b0, IN[15:8]}; rleft <= IN[7:4];
      end else if (rbusy && (!RVALID || RREADY)) begin
        RVALID <= 1'b1;
        RLAST  <= (rleft == 0);
        OUT    <= rptr[8] ? 9'h001 : {mem[rptr[7:0]], 1'b0};
        rptr   <= rptr + 9'd1;
        if (rleft == 0) rbusy <= 1'b0;
        else            rleft <= rleft - 4'd1;
      end else if (RVALID && RREADY) begin
        RVALID <= 1'b0; RLAST <= 1'b0;
      end
      if (AWVALID && AWREADY) begin
        wbusy <= 1'b1; wptr <= AWIN[11:4]; wid <= AWIN[3:0];
      end
      if (WVALID && WREADY) begin
        mem[wptr] <= WDATA;
        wptr <= wptr + 8'd1;
        if (WLAST) BVALID <= 1'b1;
      end
      if (BVALID && BREADY) begin
        BVALID <= 1'b0; wbusy <= 1'b0; wdly <= w_delay;
      end else if (wdly != 0) begin
        wdly <= wdly - 1;
      end
    end
  end

  // Scoreboard: read beats and completions are popped against what each test pushed.
  always @(negedge clk) begin
    if (!rst) begin
      if (AWVALID && !WIDLE) aw_viol++;
      if (rd_valid) begin
        tests_run++;
        if (exp_rd.size() == 0) begin
          tests_failed++;
          $display("FAIL rd_beat unexpected got={data,err,last}=%h", {rd_data, rd_err, rd_last});
        end else begin
          logic [9:0] e;
          e = exp_rd.pop_front();
          if ({rd_data, rd_err, rd_last} !== e) begin
            tests_failed++;
            $display("FAIL rd_beat got=%h exp=%h", {rd_data, rd_err, rd_last}, e);
          end
        end
      end
      if (done) begin
        done_cnt++;
        tests_run++;
        if (exp_done.size() == 0) begin
          tests_failed++;
          $display("FAIL done unexpected resp=%h tmo=%b", done_resp, done_tmo);
        end else begin
          logic [5:0] e;
          e = exp_done.pop_front();
          if ({done_resp, done_tmo} !== e) begin
            tests_failed++;
            $display("FAIL done_resp got={resp,tmo}=%h exp=%h", {done_resp, done_tmo}, e);
          end
        end
      end
    end
  end

  // Offers a command at posedge+1 and returns just after the accepting edge.
  task automatic issue_cmd(input logic w, input logic [7:0] a, input logic [3:0] l,
                           input logic [3:0] id);
    bit ok;
    ok = 1'b0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l; cmd_id = id;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL cmd_accept got=0 exp=1");
    end
  endtask

  task automatic feed_write(input logic [3:0] len, input int gap_at, input int gap_len,
                            output int beats, output bit seen_done);
    int idx, gcnt;
    bit took, gap;
    idx = 0; gcnt = 0; seen_done = 1'b0;
    for (int cyc = 0; cyc < 300 && !seen_done; cyc++) begin
      gap      = (idx == gap_at) && (gcnt < gap_len);
      wd_valid = (idx <= int'(len)) && !gap;
      wd_data  = (idx <= 15) ? wbytes[idx] : 8'h00;
      @(negedge clk);
      took = wd_valid && wd_ready;
      if (WVALID && WREADY) begin
        tests_run++;
        if ((WLAST !== (idx == int'(len))) || (WDATA !== wbytes[idx])) begin
          tests_failed++;
          $display("FAIL w_beat%0d got last=%b data=%h exp last=%b data=%h",
                   idx, WLAST, WDATA, (idx == int'(len)), wbytes[idx]);
        end
      end
      if (done) seen_done = 1'b1;
      @(posedge clk); #1;
      if (took)     idx++;
      else if (gap) gcnt++;
    end
    wd_valid = 1'b0;
    beats = idx;
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    logic [53:0] obs;
    @(negedge clk);
    obs = {cmd_ready, wd_ready, rd_data, rd_err, rd_valid, rd_last, done, done_resp, done_tmo,
           ARVALID, IN, RREADY, AWVALID, AWIN, WVALID, WLAST, BREADY};
    tests_run++;
    if (obs !== {1'b1, 53'b0}) begin
      tests_failed++;
      $display("FAIL reset_outputs got=%h exp=%h", obs, {1'b1, 53'b0});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_basic;
    int beats; bit seen;
    for (int i = 0; i < 4; i++) wbytes[i] = 8'hA0 + 8'(i);
    exp_done.push_back({5'h05, 1'b0});
    issue_cmd(1'b1, 8'h10, 4'd3, 4'd5);
    feed_write(4'd3, 99, 0, beats, seen);
    tests_run++;
    if (!seen || beats != 4) begin
      tests_failed++;
      $display("FAIL write_basic_beats got done=%b beats=%0d exp done=1 beats=4", seen, beats);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (mem[8'h10 + i] !== 8'hA0 + 8'(i)) begin
        tests_failed++;
        $display("FAIL write_basic_mem[%0d] got=%h exp=%h", i, mem[8'h10 + i], 8'hA0 + 8'(i));
      end
    end
  endtask

  task automatic test_read_basic;
    bit seen;
    for (int i = 0; i < 4; i++) exp_rd.push_back({8'hA0 + 8'(i), 1'b0, i == 3});
    exp_done.push_back({5'h02, 1'b0});
    issue_cmd(1'b0, 8'h10, 4'd3, 4'd2);
    wait_done(seen);
    tests_run++;
    if (!seen || exp_rd.size() != 0) begin
      tests_failed++;
      $display("FAIL read_basic_complete got done=%b left=%0d exp done=1 left=0", seen, exp_rd.size());
    end
  endtask

  task automatic test_read_error;
    bit seen;
    exp_rd.push_back({init_byte(8'hFE), 1'b0, 1'b0});
    exp_rd.push_back({init_byte(8'hFF), 1'b0, 1'b0});
    exp_rd.push_back({8'h00, 1'b1, 1'b0});
    exp_rd.push_back({8'h00, 1'b1, 1'b1});
    exp_done.push_back({5'h19, 1'b0});
    issue_cmd(1'b0, 8'hFE, 4'd3, 4'd9);
    wait_done(seen);
    tests_run++;
    if (!seen || exp_rd.size() != 0) begin
      tests_failed++;
      $display("FAIL read_error_complete got done=%b left=%0d exp done=1 left=0", seen, exp_rd.size());
    end
  endtask

  task automatic test_write_gaps;
    int beats; bit seen;
    for (int i = 0; i < 4; i++) wbytes[i] = 8'hB0 + 8'(i);
    exp_done.push_back({5'h06, 1'b0});
    issue_cmd(1'b1, 8'h20, 4'd3, 4'd6);
    feed_write(4'd3, 2, 2, beats, seen);
    tests_run++;
    if (!seen || beats != 4) begin
      tests_failed++;
      $display("FAIL write_gaps_beats got done=%b beats=%0d exp done=1 beats=4", seen, beats);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (mem[8'h20 + i] !== 8'hB0 + 8'(i)) begin
        tests_failed++;
        $display("FAIL write_gaps_mem[%0d] got=%h exp=%h", i, mem[8'h20 + i], 8'hB0 + 8'(i));
      end
    end
  endtask

  // ARREADY held low: ARVALID stays up for TIMEOUT cycles, then an aborted completion.
  task automatic test_timeout;
    int cnt; bit seen;
    ar_en = 1'b0;
    exp_done.push_back({5'h00, 1'b1});
    issue_cmd(1'b0, 8'h30, 4'd0, 4'd7);
    cnt = 0; seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        tests_run++;
        if (ARVALID !== 1'b0) begin
          tests_failed++;
          $display("FAIL timeout_arvalid got=%b exp=0", ARVALID);
        end
      end else if (ARVALID) begin
        cnt++;
      end
    end
    tests_run++;
    if (!seen || cnt != 63) begin
      tests_failed++;
      $display("FAIL timeout_cycles got done=%b cycles=%0d exp done=1 cycles=63", seen, cnt);
    end
    @(posedge clk); #1;
    ar_en = 1'b1;
  endtask

  task automatic test_wait_idle;
    int beats, wait_cyc; bit seen;
    w_delay = 8;
    aw_viol = 0;
    for (int i = 0; i < 4; i++) wbytes[i] = 8'hC0 + 8'(i);
    exp_done.push_back({5'h03, 1'b0});
    issue_cmd(1'b1, 8'h40, 4'd3, 4'd3);
    feed_write(4'd3, 99, 0, beats, seen);
    for (int i = 0; i < 2; i++) wbytes[i] = 8'hD0 + 8'(i);
    exp_done.push_back({5'h04, 1'b0});
    issue_cmd(1'b1, 8'h44, 4'd1, 4'd4);
    wait_cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (AWVALID) break;
      wait_cyc++;
    end
    @(posedge clk); #1;
    feed_write(4'd1, 99, 0, beats, seen);
    tests_run++;
    if (wait_cyc < 2 || aw_viol != 0) begin
      tests_failed++;
      $display("FAIL wait_idle got wait=%0d viol=%0d exp wait>=2 viol=0", wait_cyc, aw_viol);
    end
    tests_run++;
    if (!seen || mem[8'h44] !== 8'hD0 || mem[8'h45] !== 8'hD1) begin
      tests_failed++;
      $display("FAIL wait_idle_mem got done=%b %h %h exp done=1 d0 d1", seen, mem[8'h44], mem[8'h45]);
    end
    w_delay = 0;
  endtask

  task automatic test_reset_mid_burst;
    logic [53:0] obs;
    int dcnt;
    bit got;
    for (int i = 0; i < 16; i++) exp_rd.push_back({init_byte(i), 1'b0, i == 15});
    issue_cmd(1'b0, 8'h00, 4'd15, 4'd1);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (rd_valid) got = 1'b1;
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    obs = {cmd_ready, wd_ready, rd_data, rd_err, rd_valid, rd_last, done, done_resp, done_tmo,
           ARVALID, IN, RREADY, AWVALID, AWIN, WVALID, WLAST, BREADY};
    tests_run++;
    if (!got || obs !== {1'b1, 53'b0}) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs got beat=%b out=%h exp beat=1 out=%h", got, obs, {1'b1, 53'b0});
    end
    exp_rd.delete();
    dcnt = done_cnt;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    tests_run++;
    if (done_cnt != dcnt || cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_reset_no_done got dones=%0d ready=%b exp dones=0 ready=1",
               done_cnt - dcnt, cmd_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
    wd_valid = 1'b0; wd_data = '0;
    ar_en = 1'b1; aw_en = 1'b1; w_delay = 0;
    for (int i = 0; i < 16; i++) wbytes[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset;
    test_write_basic;
    test_read_basic;
    test_read_error;
    test_write_gaps;
    test_timeout;
    test_wait_idle;
    test_reset_mid_burst;
    tests_run++;
    if (exp_done.size() != 0) begin
      tests_failed++;
      $display("FAIL done_queue_left got=%0d exp=0", exp_done.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
